// File: rtl/zdrode_pkg.sv
// zdrode_pkg: shared record slicing, TX state encoding and widths for the event byte return path
package zdrode_pkg;
  localparam int SEQ_W = 4;
  localparam int DROP_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} tx_state_t;
  function automatic logic [7:0] rec_hi(input logic [15:0] r);
    return r[15:8];
  endfunction
  function automatic logic [7:0] rec_lo(input logic [15:0] r);
    return r[7:0];
  endfunction
endpackage

// File: rtl/record_fifo.sv
// record_fifo: synchronous record FIFO exposing head and the entry behind it
module record_fifo #(
  parameter int W = 16,
  parameter int D = 4,
  parameter int CW = $clog2(D) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] peek,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic pe, qe;
  assign full = count == CW'(D);
  assign empty = count == '0;
  assign qe = pop & !empty;
  assign pe = push & (!full | qe);
  assign dout = mem[rp];
  assign peek = mem[rp + AW'(1)];
  always_ff @(posedge clk)
    if (pe) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (pe) wp <= wp + AW'(1);
      if (qe) rp <= rp + AW'(1);
      count <= count + CW'(pe) - CW'(qe);
    end
endmodule

// File: rtl/event_byte_tx.sv
// event_byte_tx: queues spike/event records and serialises them MSB byte first with valid/ready
module event_byte_tx
  import zdrode_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SEND_ALL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   result_valid,
  input  logic [NUM_UNITS-1:0]   spike_array,
  input  logic [2*NUM_UNITS-1:0] event_array,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   tx_busy,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);
  localparam int SW = DATA_WIDTH - 3 * NUM_UNITS;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_WIDTH-1:0] rec, head, peek;
  logic [CW-1:0] count;
  logic full, empty, push, pop, want, valid_n;
  logic [7:0] byte_n;
  logic [SW-1:0] seq;
  tx_state_t state, state_n;
  assign rec = {seq, spike_array, event_array};
  assign want = result_valid & ((SEND_ALL != 0) | (|spike_array) | (|event_array));
  assign push = want & (!full | pop);
  assign tx_busy = (state != IDLE) | (count != '0);
  record_fifo #(.W(DATA_WIDTH), .D(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(rec),
    .dout(head), .peek(peek), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    byte_n = byte_out;
    valid_n = byte_valid;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_n = HI;
        byte_n = rec_hi(head);
        valid_n = 1'b1;
      end
      HI: if (byte_ready) begin
        state_n = LO;
        byte_n = rec_lo(head);
      end
      LO: if (byte_ready) begin
        pop = 1'b1;
        state_n = count > CW'(1) ? HI : IDLE;
        byte_n = count > CW'(1) ? rec_hi(peek) : byte_out;
        valid_n = count > CW'(1);
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      byte_out <= '0;
      byte_valid <= 1'b0;
      seq <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      byte_out <= byte_n;
      byte_valid <= valid_n;
      if (result_valid) seq <= seq + SW'(1);
      if (want & !push) begin
        overflow <= 1'b1;
        drop_count <= drop_count + {7'd0, drop_count != 8'hFF};
      end
    end
endmodule
